serial_adder_bitwise: RTL and testbench

//  Bit-serial N-bit adder built around the half-adder cell. Operands are accepted

---
 rtl/serial_add_pkg.sv | 15 +
 rtl/serial_adder_bitwise_fa_cell.sv | 25 ++
 rtl/serial_adder_bitwise.sv | 102 ++++++++++
 tb/tb_serial_adder_bitwise.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared FSM state encodings and sizing helper for the bit-serial adder.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit counter width: wide enough to hold values up to and including width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_bitwise_fa_cell.sv
// Half-adder cell and the 1-bit full adder built from two of them plus an OR.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s1, c1, c2;

  half_adder u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
  half_adder u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

  assign cout = c1 | c2;
endmodule

// File: rtl/serial_adder_bitwise.sv
// Bit-serial WIDTH-bit adder: operands in over valid/ready, one bit per clock
// LSB-first through a single full-adder cell, result out over valid/ready.
module serial_adder_bitwise
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry, s_bit, c_bit;

  fa_cell u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .s   (s_bit),
    .cout(c_bit)
  );

  // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  always_comb begin
    s_nxt            = s_sr >> 1;
    s_nxt[WIDTH-1]   = s_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      s_sr      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= a;
            b_sr     <= b;
            carry    <= cin;
            cnt      <= '0;
            state    <= ST_SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          s_sr  <= s_nxt;
          carry <= c_bit;
          cnt   <= cnt + CNT_W'(1);
          // Outputs are loaded only here, so a partial sum is never visible.
          if (cnt == LAST) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            sum       <= s_nxt;
            cout      <= c_bit;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_bitwise.sv
// Bench for serial_adder_bitwise: WIDTH=8 and WIDTH=1 instances against an arithmetic model.
module tb_serial_adder_bitwise;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, cin = 1'b0, cout, busy;
  logic [7:0] a = '0, b = '0, sum;

  logic       w1_in_valid = 1'b0, w1_in_ready, w1_out_valid, w1_out_ready = 1'b0;
  logic       w1_cin = 1'b0, w1_cout, w1_busy;
  logic [0:0] w1_a = '0, w1_b = '0, w1_sum;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  serial_adder_bitwise #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_adder_bitwise #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
    .a(w1_a), .b(w1_b), .cin(w1_cin), .out_valid(w1_out_valid), .out_ready(w1_out_ready),
    .sum(w1_sum), .cout(w1_cout), .busy(w1_busy)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation on the WIDTH=8 instance; called #1 after a rising edge while idle.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                     output logic [7:0] rs, output logic rc, output int lat);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum; rc = cout;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    vec_t       vecs[4];
    logic [7:0] rs, ea, eb, hold_sum;
    logic       rc, ec, hold_cout;
    logic [8:0] model;
    int         lat, nrise, last_rise;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum", {56'd0, sum}, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_w1_in_ready", {63'd0, w1_in_ready}, 64'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 4; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat);
      check($sformatf("vec%0d_sum", i), {56'd0, rs}, {56'd0, vecs[i].sum});
      check($sformatf("vec%0d_cout", i), {63'd0, rc}, {63'd0, vecs[i].cout});
      check($sformatf("vec%0d_latency", i), lat, 8);
    end

    // Random operands against arithmetic model
    for (int i = 0; i < 40; i++) begin
      ea = 8'($urandom); eb = 8'($urandom); ec = 1'($urandom);
      model = {1'b0, ea} + {1'b0, eb} + {8'd0, ec};
      op8(ea, eb, ec, rs, rc, lat);
      check("rand_sum", {56'd0, rs}, {56'd0, model[7:0]});
      check("rand_cout", {63'd0, rc}, {63'd0, model[8]});
    end

    // Backpressure in DONE with in_valid pulsing new data
    a = 8'hC8; b = 8'h64; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", lat, 8);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      check("bp_sum", {56'd0, sum}, 64'h2D);
      check("bp_cout", {63'd0, cout}, 64'd1);
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", {63'd0, out_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("bp_not_taken_busy", {63'd0, busy}, 64'd0);
    check("bp_not_taken_ready", {63'd0, in_ready}, 64'd1);

    // Reset during the third SHIFT cycle
    op8(8'h3C, 8'h42, 1'b0, rs, rc, lat);
    check("pre_rst_sum", {56'd0, rs}, 64'h7E);
    a = 8'h77; b = 8'h11; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_sum", {56'd0, sum}, 64'd0);
    check("mid_rst_cout", {63'd0, cout}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    op8(8'h10, 8'h20, 1'b0, rs, rc, lat);
    check("post_rst_sum", {56'd0, rs}, 64'h30);
    check("post_rst_cout", {63'd0, rc}, 64'd0);

    // Back-to-back with in_valid and out_ready held high
    a = 8'h3C; b = 8'h42; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    nrise = 0; last_rise = -1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        check("b2b_sum", {56'd0, sum}, 64'h7F);
        if (last_rise >= 0) check("b2b_period", cyc - last_rise, 10);
        last_rise = cyc;
        nrise++;
      end
    end
    in_valid = 1'b0;
    check("b2b_count", nrise, 4);
    lat = 0;
    while (busy && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_drain", {63'd0, busy}, 64'd0);
    out_ready = 1'b0;

    // WIDTH=1 instance
    w1_a = 1'b1; w1_b = 1'b1; w1_cin = 1'b1; w1_in_valid = 1'b1;
    @(posedge clk); #1;
    w1_in_valid = 1'b0;
    lat = 0;
    while (!w1_out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w1_latency", lat, 1);
    check("w1_sum", {63'd0, w1_sum}, 64'd1);
    check("w1_cout", {63'd0, w1_cout}, 64'd1);
    w1_out_ready = 1'b1;
    @(posedge clk); #1;
    w1_out_ready = 1'b0;
    check("w1_drop", {63'd0, w1_out_valid}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      ea = 8'($urandom_range(0, 1)); eb = 8'($urandom_range(0, 1)); ec = 1'($urandom);
      model = {1'b0, ea} + {1'b0, eb} + {8'd0, ec};
      w1_a = ea[0]; w1_b = eb[0]; w1_cin = ec; w1_in_valid = 1'b1;
      @(posedge clk); #1;
      w1_in_valid = 1'b0;
      lat = 0;
      while (!w1_out_valid && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      check("w1_rand_sum", {63'd0, w1_sum}, {63'd0, model[0]});
      check("w1_rand_cout", {63'd0, w1_cout}, {63'd0, model[1]});
      w1_out_ready = 1'b1;
      @(posedge clk); #1;
      w1_out_ready = 1'b0;
    end

    hold_sum = sum; hold_cout = cout;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
